// File: rtl/qce_pkg.sv
// Shared types and constants for the quantum-state normalizer slice.
package qce_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int HDR_ADDR   = 0;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        READ_N,
        HDR,
        LOAD_SUM,
        STREAM,
        DRAIN
    } state_t;

    // Sign bit is ignored so that both +0 and -0 count as zero.
    function automatic logic is_fp_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/fp_div_stage.sv
// fp32 divide (round-to-nearest-even, subnormals honoured) followed by a
// registered quotient with a valid bit; zero_override_i forces a +0 result.
module fp_div_stage
    import qce_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        zero_override_i,
    output logic        out_valid_o,
    output logic [31:0] quotient_o
);

    // Split a finite non-zero operand into an unbiased-by-one exponent and a
    // mantissa normalised so that bit 23 is set (subnormals shifted up).
    function automatic void unpack(input logic [31:0] x, output int e, output logic [23:0] m);
        e = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        m = {x[30:23] != 8'd0, x[22:0]};
        for (int i = 0; i < 23; i++) begin
            if (!m[23]) begin
                m = m << 1;
                e = e - 1;
            end
        end
    endfunction

    function automatic logic [31:0] fp32_div(input logic [31:0] a, input logic [31:0] b);
        logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rem_nz, round_up;
        logic [23:0] ma, mb;
        logic [49:0] num;
        logic [26:0] q;
        logic [25:0] m;
        logic [24:0] mant_r;
        int          ea, eb, e, sh;
        sign   = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = is_fp_zero(a);
        b_zero = is_fp_zero(b);
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return FP32_QNAN;
        if (a_inf || b_zero) return {sign, 8'hFF, 23'd0};
        if (a_zero || b_inf) return {sign, 31'd0};

        unpack(a, ea, ma);
        unpack(b, eb, mb);
        num    = {ma, 26'd0};
        q      = 27'(num / {26'd0, mb});
        rem_nz = (num % {26'd0, mb}) != 50'd0;
        e      = ea - eb + 127;
        // m = 24-bit mantissa, guard bit, sticky bit
        if (q[26]) begin
            m = {q[26:2], q[1] | q[0] | rem_nz};
        end else begin
            m = {q[25:1], q[0] | rem_nz};
            e = e - 1;
        end
        if (e < 1) begin
            sh = 1 - e;
            for (int i = 0; i < 26; i++) begin
                if (i < sh) m = {1'b0, m[25:2], m[1] | m[0]};
            end
            e = 0;
        end
        round_up = m[1] & (m[0] | m[2]);
        mant_r   = {1'b0, m[25:2]} + 25'(round_up);
        if (mant_r[24]) begin
            mant_r = mant_r >> 1;
            e      = e + 1;
        end else if (e == 0 && mant_r[23]) begin
            e = 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, 8'(e), mant_r[22:0]};
    endfunction

    logic [31:0] quotient_d;

    always_comb begin
        quotient_d = zero_override_i ? FP32_ZERO : fp32_div(dividend_i, divisor_i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_o <= 1'b0;
            quotient_o  <= FP32_ZERO;
        end else begin
            out_valid_o <= in_valid_i;
            if (in_valid_i) quotient_o <= quotient_d;
        end
    end

endmodule

// File: rtl/q_state_normalizer.sv
// Reads N and the accumulated sum from the state SRAM, then streams every
// element divided by the sum into the output SRAM at one word per cycle.
module q_state_normalizer
    import qce_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              out_write_enable,
    output logic [ADDR_W-1:0] out_write_address,
    output logic [DATA_W-1:0] out_write_data,
    output logic              norm_error
);

    localparam logic [DATA_W-1:0] MAX_N = DATA_W'(2 ** ADDR_W - 2);

    state_t              state_q;
    logic                ready_q, err_q, zero_sum_q, hdr_we_q;
    logic                rd_elem_q, data_vld_q;
    logic [ADDR_W-1:0]   n_q, rd_addr_q, wr_idx_q;
    logic [DATA_W-1:0]   sum_q;
    logic                div_valid;
    logic [31:0]         quotient;

    fp_div_stage u_div (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid_i      (data_vld_q),
        .dividend_i      (sram_read_data),
        .divisor_i       (sum_q),
        .zero_override_i (zero_sum_q),
        .out_valid_o     (div_valid),
        .quotient_o      (quotient)
    );

    // Header and element writes never overlap, so one port carries both.
    assign dut_ready         = ready_q;
    assign norm_error        = err_q;
    assign sram_read_address = rd_addr_q;
    assign out_write_enable  = hdr_we_q | div_valid;
    assign out_write_address = hdr_we_q ? ADDR_W'(HDR_ADDR) : wr_idx_q;
    assign out_write_data    = hdr_we_q ? DATA_W'(n_q) : quotient;

    // NOTE: non-blocking assignments so every branch sees pre-edge register values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            zero_sum_q <= 1'b0;
            hdr_we_q   <= 1'b0;
            rd_elem_q  <= 1'b0;
            data_vld_q <= 1'b0;
            n_q        <= '0;
            rd_addr_q  <= '0;
            wr_idx_q   <= '0;
            sum_q      <= '0;
        end else begin
            hdr_we_q   <= 1'b0;
            data_vld_q <= rd_elem_q;
            if (div_valid) wr_idx_q <= wr_idx_q + ADDR_W'(1);
            unique case (state_q)
                IDLE: begin
                    if (dut_valid) begin
                        ready_q    <= 1'b0;
                        err_q      <= 1'b0;
                        zero_sum_q <= 1'b0;
                        state_q    <= READ_N;
                    end
                end
                READ_N: begin
                    if (sram_read_data > MAX_N) begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        n_q       <= sram_read_data[ADDR_W-1:0];
                        rd_addr_q <= sram_read_data[ADDR_W-1:0] + ADDR_W'(1);
                        hdr_we_q  <= 1'b1;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (n_q == '0) begin
                        rd_addr_q <= ADDR_W'(HDR_ADDR);
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        rd_addr_q <= ADDR_W'(1);
                        rd_elem_q <= 1'b1;
                        wr_idx_q  <= ADDR_W'(1);
                        state_q   <= LOAD_SUM;
                    end
                end
                LOAD_SUM, STREAM: begin
                    if (state_q == LOAD_SUM) begin
                        sum_q <= sram_read_data;
                        if (is_fp_zero(sram_read_data)) begin
                            zero_sum_q <= 1'b1;
                            err_q      <= 1'b1;
                        end
                    end
                    if (rd_addr_q == n_q) begin
                        rd_addr_q <= ADDR_W'(HDR_ADDR);
                        rd_elem_q <= 1'b0;
                        state_q   <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        state_q   <= STREAM;
                    end
                end
                DRAIN: begin
                    if (div_valid && wr_idx_q == n_q) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
